// File: rtl/fsmc_pkg.sv
// Shared types and decode constants for the FSMC multiplexed-bus sequencer.
package fsmc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WR,
        RD,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_TFT,
        TGT_RST,
        TGT_KEY
    } target_t;

    // Latched address is {a16, da2, da1}
    localparam logic [2:0] DEC_TFT = 3'b000;
    localparam logic [2:0] DEC_RST = 3'b010;
    localparam logic [2:0] DEC_KEY = 3'b011;

    localparam int CNT_W = 16;

endpackage

// File: rtl/fsmc_sync_edge.sv
// Multi-flop synchroniser for one async pin, with rise/fall detect on the
// synchronised value.
module fsmc_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/fsmc_bus_sequencer.sv
// FSMC bus front end: synchronises the bus controls, latches the address on the
// NADV rise, drives registered chip selects and one-cycle access strobes.
module fsmc_bus_sequencer
    import fsmc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int HOLD_CYC    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ne,
    input  logic       i_nadv,
    input  logic       i_noe,
    input  logic       i_nwe,
    input  logic       i_a16,
    input  logic [1:0] i_da,
    output logic       o_tft_cs,
    output logic       o_rst_cs,
    output logic       o_key_cs,
    output logic       o_wr_stb,
    output logic       o_rd_stb,
    output logic       o_err_timeout
);

    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    function automatic target_t decode(input logic [2:0] a);
        case (a)
            DEC_TFT: decode = TGT_TFT;
            DEC_RST: decode = TGT_RST;
            DEC_KEY: decode = TGT_KEY;
            default: decode = TGT_NONE;
        endcase
    endfunction

    logic w_ne_s, w_ne_rise, w_ne_fall;
    logic w_nadv_s, w_nadv_rise, w_nadv_fall;
    logic w_noe_s, w_noe_rise, w_noe_fall;
    logic w_nwe_s, w_nwe_rise, w_nwe_fall;

    fsmc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ne (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_ne),
        .o_sync(w_ne_s), .o_rise(w_ne_rise), .o_fall(w_ne_fall));
    fsmc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nadv (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_nadv),
        .o_sync(w_nadv_s), .o_rise(w_nadv_rise), .o_fall(w_nadv_fall));
    fsmc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_noe (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_noe),
        .o_sync(w_noe_s), .o_rise(w_noe_rise), .o_fall(w_noe_fall));
    fsmc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nwe (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_nwe),
        .o_sync(w_nwe_s), .o_rise(w_nwe_rise), .o_fall(w_nwe_fall));

    // Only edges of these are needed; levels kept for symmetry of the sync cell
    logic w_unused;
    assign w_unused = &{1'b0, w_ne_rise, w_ne_fall, w_nadv_s, w_nadv_fall,
                        w_noe_s, w_nwe_s};

    // Address bits share the control-chain depth so they align with the NADV rise
    logic [SYNC_STAGES-1:0][2:0] r_bus_sync;
    logic [2:0]                  w_bus_addr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bus_sync <= '0;
        end else begin
            r_bus_sync[0] <= {i_a16, i_da};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_bus_sync[i] <= r_bus_sync[i-1];
            end
        end
    end

    assign w_bus_addr = r_bus_sync[SYNC_STAGES-1];

    state_t           r_state, w_state_n;
    logic [2:0]       r_addr, w_addr_n;
    logic             r_pend, w_pend_n;
    logic [2:0]       r_pend_addr, w_pend_addr_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic             w_tmo;
    logic             w_wr_stb_n, w_rd_stb_n, w_err_n;
    target_t          w_cs_tgt;

    always_comb begin
        w_state_n     = r_state;
        w_addr_n      = r_addr;
        w_pend_n      = r_pend;
        w_pend_addr_n = r_pend_addr;
        w_wr_stb_n    = 1'b0;
        w_err_n       = 1'b0;
        w_tmo         = (r_cnt >= TMO_LAST);

        case (r_state)
            IDLE: begin
                if (r_pend) begin
                    w_state_n = ADDR;
                    w_addr_n  = r_pend_addr;
                    w_pend_n  = 1'b0;
                end else if (!w_ne_s && w_nadv_rise) begin
                    w_state_n = ADDR;
                    w_addr_n  = w_bus_addr;
                end
            end
            ADDR: begin
                if (w_nwe_fall) begin
                    w_state_n = WR;
                end else if (w_noe_fall) begin
                    w_state_n = RD;
                end else if (w_ne_s) begin
                    w_state_n = IDLE;
                end else if (w_tmo) begin
                    w_state_n = IDLE;
                    w_err_n   = 1'b1;
                end
            end
            WR: begin
                if (w_nwe_rise) begin
                    w_state_n  = HOLD;
                    w_wr_stb_n = 1'b1;
                end else if (w_tmo) begin
                    w_state_n = IDLE;
                    w_err_n   = 1'b1;
                end
            end
            RD: begin
                if (w_noe_rise) begin
                    w_state_n = HOLD;
                end else if (w_tmo) begin
                    w_state_n = IDLE;
                    w_err_n   = 1'b1;
                end
            end
            HOLD: begin
                // Next access may start while CS is still held; remember it for IDLE
                if (w_nadv_rise) begin
                    w_pend_n      = 1'b1;
                    w_pend_addr_n = w_bus_addr;
                end
                if (r_cnt >= HOLD_LAST) begin
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase

        if (w_state_n != r_state) begin
            w_cnt_n = '0;
        end else if (r_cnt == '1) begin
            w_cnt_n = r_cnt;
        end else begin
            w_cnt_n = r_cnt + 1'b1;
        end

        w_rd_stb_n = (w_state_n == RD) && (r_state != RD);
        w_cs_tgt   = (w_state_n == IDLE) ? TGT_NONE : decode(w_addr_n);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_pend        <= 1'b0;
            r_pend_addr   <= '0;
            r_cnt         <= '0;
            o_tft_cs      <= 1'b1;
            o_rst_cs      <= 1'b1;
            o_key_cs      <= 1'b1;
            o_wr_stb      <= 1'b0;
            o_rd_stb      <= 1'b0;
            o_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_addr        <= w_addr_n;
            r_pend        <= w_pend_n;
            r_pend_addr   <= w_pend_addr_n;
            r_cnt         <= w_cnt_n;
            o_tft_cs      <= (w_cs_tgt != TGT_TFT);
            o_rst_cs      <= (w_cs_tgt != TGT_RST);
            o_key_cs      <= (w_cs_tgt != TGT_KEY);
            o_wr_stb      <= w_wr_stb_n;
            o_rd_stb      <= w_rd_stb_n;
            o_err_timeout <= w_err_n;
        end
    end

endmodule

// File: tb/tb_fsmc_bus_sequencer.sv
// Scoreboard bench for fsmc_bus_sequencer: each access pushes its expected
// strobe event; a negedge monitor pops and compares when a strobe fires.
module tb_fsmc_bus_sequencer;

    localparam int S       = 2;
    localparam int TIMEOUT = 255;
    localparam int HOLD    = 1;

    // Expected {tft_cs,rst_cs,key_cs} while the strobe is high
    localparam logic [2:0] CS_TFT  = 3'b011;
    localparam logic [2:0] CS_RST  = 3'b101;
    localparam logic [2:0] CS_KEY  = 3'b110;
    localparam logic [2:0] CS_NONE = 3'b111;

    localparam int EV_WR  = 0;
    localparam int EV_RD  = 1;
    localparam int EV_ERR = 2;

    typedef struct {
        int         kind;
        logic [2:0] cs;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ne = 1'b1, nadv = 1'b1, noe = 1'b1, nwe = 1'b1, a16 = 1'b0;
    logic [1:0] da = 2'b00;
    logic       tft_cs, rst_cs, key_cs, wr_stb, rd_stb, err_timeout;

    int  checks = 0;
    int  failures = 0;
    int  n_wr = 0, n_rd = 0, n_err = 0;
    ev_t sb[$];

    fsmc_bus_sequencer #(.SYNC_STAGES(S), .TIMEOUT(TIMEOUT), .HOLD_CYC(HOLD)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ne(ne), .i_nadv(nadv), .i_noe(noe),
        .i_nwe(nwe), .i_a16(a16), .i_da(da),
        .o_tft_cs(tft_cs), .o_rst_cs(rst_cs), .o_key_cs(key_cs),
        .o_wr_stb(wr_stb), .o_rd_stb(rd_stb), .o_err_timeout(err_timeout));

    always #5 clk = ~clk;

    // Strobe monitor and chip-select exclusivity
    always @(negedge clk) begin
        if (rst_n) begin
            logic [2:0] stb;
            logic [2:0] cs;
            stb = {err_timeout, rd_stb, wr_stb};
            cs  = {tft_cs, rst_cs, key_cs};
            checks++;
            if ($countones(~cs) > 1) begin
                failures++;
                $display("FAIL cs_onehot t=%0t cs=%b required at most one low", $time, cs);
            end
            for (int k = 0; k < 3; k++) begin
                if (stb[k]) begin
                    if (k == EV_WR) n_wr++;
                    if (k == EV_RD) n_rd++;
                    if (k == EV_ERR) n_err++;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_strobe t=%0t kind=%0d cs=%b required none", $time, k, cs);
                    end else begin
                        ev_t e;
                        e = sb.pop_front();
                        if (e.kind != k || cs !== e.cs) begin
                            failures++;
                            $display("FAIL strobe_event t=%0t kind=%0d cs=%b required kind=%0d cs=%b",
                                     $time, k, cs, e.kind, e.cs);
                        end
                    end
                end
            end
        end
    end

    task automatic push(input int kind, input logic [2:0] cs);
        ev_t e;
        e.kind = kind;
        e.cs   = cs;
        sb.push_back(e);
    endtask

    // Bank enable + address phase; leaves NADV high after its rising edge
    task automatic start_access(input logic [2:0] a);
        @(negedge clk);
        ne   = 1'b0;
        {a16, da} = a;
        nadv = 1'b0;
        @(negedge clk);
        nadv = 1'b1;
    endtask

    task automatic end_access();
        @(negedge clk);
        ne = 1'b1;
        repeat (S + 3) @(negedge clk);
    endtask

    task automatic simple_write(input logic [2:0] a, input logic [2:0] cs_exp);
        start_access(a);
        repeat (S + 2) @(negedge clk);
        nwe = 1'b0;
        push(EV_WR, cs_exp);
        repeat (4) @(negedge clk);
        nwe = 1'b1;
        repeat (S + 2) @(negedge clk);
        end_access();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tft_cs, rst_cs, key_cs, wr_stb, rd_stb, err_timeout} !== 6'b111000) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=111000",
                     {tft_cs, rst_cs, key_cs, wr_stb, rd_stb, err_timeout});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tft_cs, rst_cs, key_cs} !== CS_NONE) begin
            failures++;
            $display("FAIL idle_cs got=%b required=%b", {tft_cs, rst_cs, key_cs}, CS_NONE);
        end
    endtask

    task automatic test_write_tft();
        int w0;
        w0 = n_wr;
        start_access(3'b000);
        for (int k = 1; k <= S + 1; k++) begin
            @(negedge clk);
            checks++;
            if ({tft_cs, rst_cs, key_cs} !== ((k <= S) ? CS_NONE : CS_TFT)) begin
                failures++;
                $display("FAIL tft_cs_latency k=%0d got=%b required=%b", k,
                         {tft_cs, rst_cs, key_cs}, (k <= S) ? CS_NONE : CS_TFT);
            end
        end
        @(negedge clk);
        nwe = 1'b0;
        push(EV_WR, CS_TFT);
        repeat (6) @(negedge clk);
        nwe = 1'b1;
        for (int k = 1; k <= S + 2; k++) begin
            @(negedge clk);
            checks++;
            if (wr_stb !== (k == S + 1)) begin
                failures++;
                $display("FAIL wr_stb_latency k=%0d got=%b required=%b", k, wr_stb, (k == S + 1));
            end
        end
        checks++;
        if (tft_cs !== 1'b1) begin
            failures++;
            $display("FAIL tft_cs_release got=%b required=1", tft_cs);
        end
        end_access();
        checks++;
        if (n_wr - w0 != 1) begin
            failures++;
            $display("FAIL tft_wr_count got=%0d required=1", n_wr - w0);
        end
    endtask

    task automatic test_read_key();
        int w0, r0;
        w0 = n_wr;
        r0 = n_rd;
        start_access(3'b011);
        repeat (S + 1) @(negedge clk);
        checks++;
        if ({tft_cs, rst_cs, key_cs} !== CS_KEY) begin
            failures++;
            $display("FAIL key_cs got=%b required=%b", {tft_cs, rst_cs, key_cs}, CS_KEY);
        end
        noe = 1'b0;
        push(EV_RD, CS_KEY);
        repeat (5) @(negedge clk);
        noe = 1'b1;
        repeat (S + 2) @(negedge clk);
        end_access();
        checks++;
        if (n_rd - r0 != 1 || n_wr != w0) begin
            failures++;
            $display("FAIL key_read_counts rd=%0d wr=%0d required rd=1 wr=0", n_rd - r0, n_wr - w0);
        end
    endtask

    task automatic test_unmapped();
        logic [2:0] addrs [2];
        int w0;
        addrs[0] = 3'b001;
        addrs[1] = 3'b100;
        for (int i = 0; i < 2; i++) begin
            w0 = n_wr;
            start_access(addrs[i]);
            repeat (S + 2) @(negedge clk);
            checks++;
            if ({tft_cs, rst_cs, key_cs} !== CS_NONE) begin
                failures++;
                $display("FAIL unmapped_cs addr=%b got=%b required=%b", addrs[i],
                         {tft_cs, rst_cs, key_cs}, CS_NONE);
            end
            nwe = 1'b0;
            push(EV_WR, CS_NONE);
            repeat (4) @(negedge clk);
            nwe = 1'b1;
            repeat (S + 2) @(negedge clk);
            end_access();
            checks++;
            if (n_wr - w0 != 1) begin
                failures++;
                $display("FAIL unmapped_wr_count addr=%b got=%0d required=1", addrs[i], n_wr - w0);
            end
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int guard;
        start_access(3'b000);
        guard = 0;
        while (tft_cs !== 1'b0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (tft_cs !== 1'b0) begin
            failures++;
            $display("FAIL stall_addr_entry tft_cs=%b required=0", tft_cs);
        end
        push(EV_ERR, CS_NONE);
        cyc = 0;
        while (err_timeout !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != TIMEOUT) begin
            failures++;
            $display("FAIL timeout_cycles got=%0d required=%0d", cyc, TIMEOUT);
        end
        @(negedge clk);
        checks++;
        if ({tft_cs, rst_cs, key_cs, err_timeout} !== 4'b1110) begin
            failures++;
            $display("FAIL timeout_after got=%b required=1110", {tft_cs, rst_cs, key_cs, err_timeout});
        end
        end_access();
        simple_write(3'b011, CS_KEY);
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = n_wr;
        start_access(3'b010);
        repeat (S + 2) @(negedge clk);
        nwe = 1'b0;
        push(EV_WR, CS_RST);
        repeat (4) @(negedge clk);
        nwe  = 1'b1;
        nadv = 1'b0;
        {a16, da} = 3'b000;
        @(negedge clk);
        nadv = 1'b1;
        push(EV_WR, CS_TFT);
        repeat (S) @(negedge clk);
        checks++;
        if ({tft_cs, rst_cs, key_cs} !== CS_RST) begin
            failures++;
            $display("FAIL b2b_first_cs got=%b required=%b", {tft_cs, rst_cs, key_cs}, CS_RST);
        end
        @(negedge clk);
        checks++;
        if ({tft_cs, rst_cs, key_cs} !== CS_NONE) begin
            failures++;
            $display("FAIL b2b_gap_cs got=%b required=%b", {tft_cs, rst_cs, key_cs}, CS_NONE);
        end
        @(negedge clk);
        checks++;
        if ({tft_cs, rst_cs, key_cs} !== CS_TFT) begin
            failures++;
            $display("FAIL b2b_second_cs got=%b required=%b", {tft_cs, rst_cs, key_cs}, CS_TFT);
        end
        nwe = 1'b0;
        repeat (4) @(negedge clk);
        nwe = 1'b1;
        repeat (S + 2) @(negedge clk);
        end_access();
        checks++;
        if (n_wr - w0 != 2) begin
            failures++;
            $display("FAIL b2b_wr_count got=%0d required=2", n_wr - w0);
        end
    endtask

    task automatic test_reset_mid_write();
        int w0;
        w0 = n_wr;
        start_access(3'b000);
        repeat (S + 2) @(negedge clk);
        nwe = 1'b0;
        repeat (S + 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({tft_cs, rst_cs, key_cs, wr_stb} !== 4'b1110) begin
            failures++;
            $display("FAIL reset_mid_wr got=%b required=1110", {tft_cs, rst_cs, key_cs, wr_stb});
        end
        rst_n = 1'b1;
        nwe   = 1'b1;
        ne    = 1'b1;
        repeat (S + 4) @(negedge clk);
        checks++;
        if (n_wr != w0 || {tft_cs, rst_cs, key_cs} !== CS_NONE) begin
            failures++;
            $display("FAIL reset_mid_wr_after wr=%0d cs=%b required wr=0 cs=%b", n_wr - w0,
                     {tft_cs, rst_cs, key_cs}, CS_NONE);
        end
        simple_write(3'b010, CS_RST);
    endtask

    initial begin
        test_reset();
        test_write_tft();
        test_read_key();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_reset_mid_write();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
